vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_axis_counter.sv | 62 ++++++
 rtl/vga_timing_gen.sv | 163 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing helpers and mode presets for the VGA raster generator.
package vga_timing_pkg;

    typedef struct packed {
        int   h_visible;
        int   h_front;
        int   h_sync;
        int   h_back;
        int   v_visible;
        int   v_front;
        int   v_sync;
        int   v_back;
        logic h_pol;
        logic v_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640x480_60 = '{
        h_visible: 640, h_front: 16, h_sync: 96, h_back: 48,
        v_visible: 480, v_front: 10, v_sync: 2,  v_back: 33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam vga_mode_t MODE_800x600_60 = '{
        h_visible: 800, h_front: 40, h_sync: 128, h_back: 88,
        v_visible: 600, v_front: 1,  v_sync: 4,   v_back: 23,
        h_pol: 1'b1, v_pol: 1'b1
    };

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int sync_start(input int visible, input int front);
        return visible + front;
    endfunction

    function automatic int sync_end(input int visible, input int front, input int sync);
        return visible + front + sync;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus visible/sync decode of the next position.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter bit POL     = 1'b0,
    localparam int TOTAL  = axis_total(VISIBLE, FRONT, SYNC, BACK),
    localparam int W      = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
    output logic [W-1:0] pos,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [31:0]  VIS_END = 32'(VISIBLE);
    localparam logic [31:0]  SYNC_LO = 32'(sync_start(VISIBLE, FRONT));
    localparam logic [31:0]  SYNC_HI = 32'(sync_end(VISIBLE, FRONT, SYNC));

    logic [W-1:0] pos_q;
    logic [W-1:0] pos_d;
    logic [31:0]  pos_ext_s;

    // active/sync decode the next position so the parent can register them alongside pos_q
    always_comb begin
        wrap  = adv && (pos_q == LAST);
        pos_d = pos_q;
        if (wrap) begin
            pos_d = '0;
        end else if (adv) begin
            pos_d = pos_q + W'(1);
        end else begin
            pos_d = pos_q;
        end
        pos_ext_s = 32'(pos_d);
        active    = (pos_ext_s < VIS_END);
        if ((pos_ext_s >= SYNC_LO) && (pos_ext_s < SYNC_HI)) begin
            sync = POL;
        end else begin
            sync = ~POL;
        end
    end

    // Position register; reset parks the axis on its last (back-porch) position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= LAST;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: registered syncs, display_on, coordinates, strobes, frame count.
// Optional pixel-clock divider is compiled in with `define VGA_TIMING_CLKDIV_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int FRAME_W    = 8,
    parameter int CLK_DIV    = 1,
    localparam int H_TOTAL   = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
    localparam int V_TOTAL   = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [HW-1:0]      hpos,
    output logic [VW-1:0]      vpos,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    logic tick_s;

`ifdef VGA_TIMING_CLKDIV_EN
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             div_hit_s;

    // Divider restarts from zero whenever the tile is disabled
    always_comb begin
        div_hit_s = (div_q == DIV_LAST);
        tick_s    = ena && div_hit_s;
        if (!ena) begin
            div_d = '0;
        end else if (div_hit_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Pixel divider counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    logic unused_clk_div_s;
    assign unused_clk_div_s = (CLK_DIV > 0);

    // Every enabled clock is a pixel
    always_comb begin
        tick_s = ena;
    end
`endif

    logic h_wrap_s;
    logic h_active_s;
    logic h_sync_s;
    logic v_wrap_s;
    logic v_active_s;
    logic v_sync_s;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (H_SYNC_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (tick_s),
        .pos    (hpos),
        .wrap   (h_wrap_s),
        .active (h_active_s),
        .sync   (h_sync_s)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (V_SYNC_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (h_wrap_s),
        .pos    (vpos),
        .wrap   (v_wrap_s),
        .active (v_active_s),
        .sync   (v_sync_s)
    );

    logic               hsync_q,       hsync_d;
    logic               vsync_q,       vsync_d;
    logic               display_on_q,  display_on_d;
    logic               line_start_q,  line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;

    // Decodes follow the counters' next state; strobes are rebuilt every clk so they self-clear
    always_comb begin
        hsync_d       = h_sync_s;
        vsync_d       = v_sync_s;
        display_on_d  = h_active_s && v_active_s;
        line_start_d  = h_wrap_s;
        frame_start_d = v_wrap_s;
        if (v_wrap_s) begin
            frame_count_d = frame_count_q + FRAME_W'(1);
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '1;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default horizontal timing, shortened vertical timing (13 lines).
module tb_vga_timing_gen;

    localparam int HT = 800;
    localparam int VT = 13;
`ifdef VGA_TIMING_CLKDIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       hsync, vsync, display_on, line_start, frame_start;
    logic [9:0] hpos;
    logic [3:0] vpos;
    logic [7:0] frame_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mh, mv, mfc, gtick;

    vga_timing_gen #(
        .V_VISIBLE (6),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (3),
        .CLK_DIV   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .hsync       (hsync),
        .vsync       (vsync),
        .display_on  (display_on),
        .hpos        (hpos),
        .vpos        (vpos),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wire [26:0] obs_vec = {hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count};

    function automatic logic [26:0] exp_vec(input bit live);
        logic hs_e, vs_e, don_e, ls_e, fs_e;
        hs_e  = !((mh >= 656) && (mh < 752));
        vs_e  = !((mv >= 8) && (mv < 10));
        don_e = (mh < 640) && (mv < 6);
        ls_e  = live && (mh == 0);
        fs_e  = live && (mh == 0) && (mv == 0);
        return {mh[9:0], mv[3:0], hs_e, vs_e, don_e, ls_e, fs_e, mfc[7:0]};
    endfunction

    task automatic model_reset();
        mh = HT - 1; mv = VT - 1; mfc = 255;
    endtask

    task automatic model_tick();
        gtick++;
        if (mh == HT - 1) begin
            mh = 0;
            if (mv == VT - 1) begin mv = 0; mfc = (mfc + 1) % 256; end
            else mv++;
        end else mh++;
    endtask

    task automatic tick_n(input int n);
        repeat (n * DIV) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        model_reset();
        gtick = 0;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if (obs_vec !== exp_vec(1'b0)) begin
            bad++; $display("FAIL reset_async got %h want %h", obs_vec, exp_vec(1'b0));
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs_vec !== exp_vec(1'b0)) begin
            bad++; $display("FAIL reset_held got %h want %h", obs_vec, exp_vec(1'b0));
        end
    endtask

    task automatic test_first_tick();
        rst_n = 1'b1;
        model_tick();
        tick_n(1);
        total++;
        if (obs_vec !== exp_vec(1'b1)) begin
            bad++; $display("FAIL first_tick got %h want %h", obs_vec, exp_vec(1'b1));
        end
        ena = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({line_start, frame_start, hpos} !== {2'b00, 10'd0}) begin
            bad++; $display("FAIL strobe_clear_ena_low got %b%b/%0d want 00/0", line_start, frame_start, hpos);
        end
        ena = 1'b1;
    endtask

    task automatic test_line();
        int hs_cnt = 0, hs_first = -1, hs_last = -1, ls_a = -1, ls_b = -1;
        for (int i = 1; i <= 2 * HT; i++) begin
            model_tick();
            tick_n(1);
            total++;
            if (obs_vec !== exp_vec(1'b1)) begin
                bad++; $display("FAIL line_tick%0d got %h want %h", i, obs_vec, exp_vec(1'b1));
            end
            if ((mv == 0) && (hsync == 1'b0)) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = mh;
                hs_last = mh;
            end
            if (line_start) begin
                if (ls_a < 0) ls_a = i;
                else if (ls_b < 0) ls_b = i;
            end
        end
        total++;
        if (hs_cnt != 96) begin bad++; $display("FAIL hsync_width got %0d want 96", hs_cnt); end
        total++;
        if ((hs_first != 656) || (hs_last != 751)) begin
            bad++; $display("FAIL hsync_window got %0d..%0d want 656..751", hs_first, hs_last);
        end
        total++;
        if ((ls_a != HT) || (ls_b - ls_a != HT)) begin
            bad++; $display("FAIL line_period got %0d,%0d want 800,1600", ls_a, ls_b);
        end
    endtask

    task automatic test_frame();
        int n = 0, vs_lines = 0, vmin = 99, vmax = -1, vs_bad = 0, fs_at = -1;
        logic prev_vs;
        prev_vs = vsync;
        while ((fs_at < 0) && (n < 2 * HT * VT)) begin
            n++;
            model_tick();
            tick_n(1);
            total++;
            if (obs_vec !== exp_vec(1'b1)) begin
                bad++; $display("FAIL frame_tick%0d got %h want %h", n, obs_vec, exp_vec(1'b1));
            end
            if ((vsync !== prev_vs) && (hpos != 10'd0)) vs_bad++;
            prev_vs = vsync;
            if ((hpos == 10'd0) && (vsync == 1'b0)) begin
                vs_lines++;
                if (int'(vpos) < vmin) vmin = int'(vpos);
                if (int'(vpos) > vmax) vmax = int'(vpos);
            end
            if (frame_start) fs_at = gtick;
        end
        total++;
        if (fs_at != HT * VT + 1) begin
            bad++; $display("FAIL frame_period got tick %0d want %0d", fs_at, HT * VT + 1);
        end
        total++;
        if ((vs_lines != 2) || (vmin != 8) || (vmax != 9)) begin
            bad++; $display("FAIL vsync_window got %0d lines %0d..%0d want 2 lines 8..9", vs_lines, vmin, vmax);
        end
        total++;
        if (vs_bad != 0) begin bad++; $display("FAIL vsync_off_hpos0 got %0d want 0", vs_bad); end
        total++;
        if (frame_count !== 8'd1) begin bad++; $display("FAIL frame_count1 got %0d want 1", frame_count); end
    endtask

    task automatic test_ena_hold();
        int cyc0, n = 0;
        bit seen = 1'b0;
        cyc0 = cyc;
        for (int i = 0; i < HT + 300; i++) begin
            model_tick();
            tick_n(1);
            total++;
            if (obs_vec !== exp_vec(1'b1)) begin
                bad++; $display("FAIL pre_hold%0d got %h want %h", i, obs_vec, exp_vec(1'b1));
            end
        end
        ena = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(posedge clk); #1;
            total++;
            if (obs_vec !== exp_vec(1'b0)) begin
                bad++; $display("FAIL hold%0d got %h want %h", i, obs_vec, exp_vec(1'b0));
            end
        end
        ena = 1'b1;
        while (!seen && (n < 2 * HT * VT)) begin
            n++;
            model_tick();
            tick_n(1);
            total++;
            if (obs_vec !== exp_vec(1'b1)) begin
                bad++; $display("FAIL post_hold%0d got %h want %h", n, obs_vec, exp_vec(1'b1));
            end
            if (frame_start) seen = 1'b1;
        end
        total++;
        if (!seen || (cyc - cyc0 != HT * VT * DIV + 37)) begin
            bad++; $display("FAIL stretched_frame got %0d cycles want %0d", cyc - cyc0, HT * VT * DIV + 37);
        end
        total++;
        if (frame_count !== 8'd2) begin bad++; $display("FAIL frame_count2 got %0d want 2", frame_count); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5 * HT + 300; i++) begin
            model_tick();
            tick_n(1);
        end
        total++;
        if ({hpos, vpos} !== {10'd300, 4'd5}) begin
            bad++; $display("FAIL reach_300_5 got %0d,%0d want 300,5", hpos, vpos);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec !== exp_vec(1'b0)) begin
            bad++; $display("FAIL midframe_reset got %h want %h", obs_vec, exp_vec(1'b0));
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            model_tick();
            tick_n(1);
            total++;
            if (obs_vec !== exp_vec(1'b1)) begin
                bad++; $display("FAIL restart%0d got %h want %h", i, obs_vec, exp_vec(1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_line();
        test_frame();
        test_ena_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
